// File: rtl/pipe_fft_twid_pkg.sv
// Shared types and constants for the pipelined-FFT twiddle RAM sequencer.
// The table-load checksum (optional, macro PIPE_FFT_TWID_LOAD_CKSUM_EN)
// uses CKSUM_W and slice_sum() from here.
package pipe_fft_twid_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } twid_state_e;

  localparam int TWID_DEPTH  = 64;
  localparam int TWID_ADDR_W = 6;
  localparam int TWID_DATA_W = 64;
  localparam int CKSUM_W     = 16;

  // Modular sum of the 16-bit slices of one twiddle word.
  function automatic logic [CKSUM_W-1:0] slice_sum(input logic [TWID_DATA_W-1:0] w);
    logic [CKSUM_W-1:0] acc;
    // NOTE: blocking assignments are correct here: acc is a local temporary
    // evaluated in order, not a flop updated at a clock edge.
    acc = '0;
    for (int i = 0; i < TWID_DATA_W / CKSUM_W; i++) begin
      acc = acc + w[i*CKSUM_W +: CKSUM_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/pipe_fft_twid_addr_gen.sv
// Strided twiddle read-address generator for one FFT stage.
// rAddr always holds (k << s) mod 2**ADDR_W for the current k, so the RAM
// samples the address of twiddle k in the very cycle k is issued.
module pipe_fft_twid_addr_gen
  import pipe_fft_twid_pkg::*;
#(
  parameter int ADDR_W = TWID_ADDR_W,
  parameter int STG_W  = 3
) (
  input  logic              clk,
  input  logic              nGrst,
  input  logic              clr,
  input  logic              adv,
  input  logic [STG_W-1:0]  s,
  output logic [ADDR_W-1:0] rAddr,
  output logic [ADDR_W-1:0] k,
  output logic              last_issue
);

  logic [ADDR_W-1:0] k_nxt;

  assign k_nxt      = k + ADDR_W'(1);
  assign last_issue = adv & (k == '1);

  // k counter and registered read address; shifts of s >= ADDR_W fall off to 0.
  always_ff @(posedge clk or negedge nGrst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!nGrst) begin
      k     <= '0;
      rAddr <= '0;
    end else if (clr) begin
      k     <= '0;
      rAddr <= '0;
    end else if (adv) begin
      k     <= k_nxt;
      rAddr <= k_nxt << s;
    end
  end

endmodule

// File: rtl/pipe_fft_twid_ctrl.sv
// Twiddle RAM sequencer: loads 64 words through a valid/ready stream into the
// RAM write port, then issues the strided read sequence for one FFT stage
// with a valid/last strobe delayed by the RAM read latency.
// Optional feature: define PIPE_FFT_TWID_LOAD_CKSUM_EN to add ld_cksum /
// cksum_err and qualify table_ok with a 16-bit slice checksum.
module pipe_fft_twid_ctrl
  import pipe_fft_twid_pkg::*;
#(
  parameter int ADDR_W = TWID_ADDR_W,
  parameter int DATA_W = TWID_DATA_W,
  parameter int RD_LAT = 2,
  parameter int STG_W  = 3
) (
  input  logic               clk,
  input  logic               nGrst,
  input  logic               load_start,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               ld_ready,
  output logic               load_done,
  output logic               table_ok,
`ifdef PIPE_FFT_TWID_LOAD_CKSUM_EN
  input  logic [CKSUM_W-1:0] ld_cksum,
  output logic               cksum_err,
`endif
  input  logic               stage_start,
  input  logic [STG_W-1:0]   stage_idx,
  input  logic               run_en,
  output logic               twid_valid,
  output logic               twid_last,
  output logic               busy,
  output logic               cmd_err,
  output logic               wEn,
  output logic [ADDR_W-1:0]  wAddr,
  output logic [DATA_W-1:0]  wD,
  output logic [ADDR_W-1:0]  rAddr
);

  localparam int DCNT_W = $clog2(RD_LAT + 1);

  twid_state_e       state, state_nxt;
  logic [ADDR_W-1:0] lcnt;
  logic [STG_W-1:0]  s_q;
  logic [ADDR_W-1:0] k_cnt;
  logic [DCNT_W-1:0] dcnt;
  logic [RD_LAT-1:0] vpipe, lpipe;
  logic              wr_en, issue, cmd_rej, take_load, take_stage, load_last;
  logic              last_issue, table_good;

  pipe_fft_twid_addr_gen #(
    .ADDR_W (ADDR_W),
    .STG_W  (STG_W)
  ) u_addr_gen (
    .clk        (clk),
    .nGrst      (nGrst),
    .clr        (take_stage),
    .adv        (issue),
    .s          (s_q),
    .rAddr      (rAddr),
    .k          (k_cnt),
    .last_issue (last_issue)
  );

  // State register.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_nxt  = state;
    ld_ready   = 1'b0;
    wr_en      = 1'b0;
    issue      = 1'b0;
    cmd_rej    = 1'b0;
    take_load  = 1'b0;
    take_stage = 1'b0;
    load_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) begin
          // A simultaneous stage_start loses to the load and is rejected.
          state_nxt = ST_LOAD;
          take_load = 1'b1;
          cmd_rej   = stage_start;
        end else if (stage_start) begin
          if (table_ok) begin
            state_nxt  = ST_RUN;
            take_stage = 1'b1;
          end else begin
            cmd_rej = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        ld_ready = 1'b1;
        wr_en    = ld_valid;
        cmd_rej  = load_start | stage_start;
        if (wr_en && lcnt == '1) begin
          load_last = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        issue   = run_en;
        cmd_rej = load_start | stage_start;
        if (run_en && k_cnt == '1) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        cmd_rej = load_start | stage_start;
        if (dcnt == DCNT_W'(RD_LAT - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Load counter, table status, stage latch and one-cycle status pulses.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      lcnt      <= '0;
      table_ok  <= 1'b0;
      load_done <= 1'b0;
      cmd_err   <= 1'b0;
      s_q       <= '0;
    end else begin
      load_done <= load_last;
      cmd_err   <= cmd_rej;
      if (take_load) begin
        lcnt     <= '0;
        table_ok <= 1'b0;
      end else if (wr_en) begin
        lcnt <= lcnt + ADDR_W'(1);
        if (load_last) table_ok <= table_good;
      end
      if (take_stage) s_q <= stage_idx;
    end
  end

  // DRAIN dwell counter: restarts whenever DRAIN is not the current state.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst)                 dcnt <= '0;
    else if (state != ST_DRAIN) dcnt <= '0;
    else                        dcnt <= dcnt + DCNT_W'(1);
  end

  // Valid/last pipe matching the RAM read latency; shifts every cycle.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      vpipe <= '0;
      lpipe <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(issue);
      lpipe <= (lpipe << 1) | RD_LAT'(last_issue);
    end
  end

`ifdef PIPE_FFT_TWID_LOAD_CKSUM_EN
  logic [CKSUM_W-1:0] cksum_acc, cksum_nxt;

  assign cksum_nxt  = cksum_acc + slice_sum(TWID_DATA_W'(ld_data));
  assign table_good = (cksum_nxt == ld_cksum);

  // Running checksum of the table being loaded; verdict pulses with load_done.
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      cksum_acc <= '0;
      cksum_err <= 1'b0;
    end else begin
      cksum_err <= load_last & ~table_good;
      if (take_load)  cksum_acc <= '0;
      else if (wr_en) cksum_acc <= cksum_nxt;
    end
  end
`else
  assign table_good = 1'b1;
`endif

  assign twid_valid = vpipe[RD_LAT-1];
  assign twid_last  = lpipe[RD_LAT-1];
  assign busy       = (state != ST_IDLE);
  assign wEn        = wr_en;
  assign wAddr      = ld_ready ? lcnt : '0;
  assign wD         = ld_ready ? ld_data : '0;

endmodule

// File: doc/pipe_fft_twid_ctrl.md
Name: pipe_fft_twid_ctrl

Overview:
Sequencer for the 64x64 pipelined-FFT twiddle RAM, which has separate read and write ports with registered address and registered data.
- Load phase: accepts 64 twiddle words over a valid/ready stream and drives the RAM write port.
- Run phase: generates the strided read-address sequence for one FFT stage, plus a valid/last strobe aligned to the RAM read latency.
- Sits between the FFT top-level control FSM and the twiddle RAM; rClk and wClk of the RAM are both tied to clk.

Parameters:
- ADDR_W, 6, twiddle RAM address width (depth 2**ADDR_W = 64).
- DATA_W, 64, twiddle word width.
- RD_LAT, 2, RAM read latency in clk cycles (registered address plus registered data).
- STG_W, 3, width of stage index.

Ports:
- clk  in  1  single clock for controller and both RAM ports.
- nGrst  in  1  asynchronous active-low reset.
- load_start  in  1  pulse: begin table load.
- ld_valid  in  1  load word valid.
- ld_data  in  DATA_W  load word.
- ld_ready  out  1  controller accepts a load word.
- load_done  out  1  one-cycle pulse after the 64th word is written.
- table_ok  out  1  table is loaded and valid.
- stage_start  in  1  pulse: begin twiddle sequence for one stage.
- stage_idx  in  STG_W  stage number, sampled on an accepted stage_start.
- run_en  in  1  advance enable; 0 stalls address issue.
- twid_valid  out  1  RAM rD holds a requested twiddle this cycle.
- twid_last  out  1  accompanies the twid_valid for k=63.
- busy  out  1  controller is not in IDLE.
- cmd_err  out  1  one-cycle pulse on a rejected command.
- wEn  out  1  RAM write enable.
- wAddr  out  ADDR_W  RAM write address.
- wD  out  DATA_W  RAM write data.
- rAddr  out  ADDR_W  RAM read address.

Behaviour:
Reset values:
- All outputs are 0; state is IDLE; table_ok=0; counters are 0.
- Reset asserted mid-load or mid-run aborts immediately; table_ok is cleared and the table must be reloaded.

States: IDLE, LOAD, RUN, DRAIN.

IDLE:
- load_start -> LOAD; clear table_ok and the load counter.
- stage_start with table_ok=1 -> RUN; latch stage_idx into s; clear k.
- stage_start with table_ok=0 -> cmd_err pulse, stay in IDLE.
- load_start and stage_start in the same cycle: load wins; cmd_err pulses.

LOAD:
- ld_ready=1.
- Write strobe: wEn = ld_valid & ld_ready, combinational from ld_valid.
- wAddr = lcnt; wD = ld_data.
- lcnt increments on each write.
- On the write with lcnt=63: next state IDLE, load_done pulses the following cycle, table_ok=1.
- load_start or stage_start while in LOAD: ignored, cmd_err pulses.

RUN:
- rAddr = (k << s) mod 64, registered; any s is legal, and s>=6 yields address 0 throughout.
- Issue strobe: issue = run_en.
- On issue, k increments. run_en=0 holds both rAddr and k.
- Issue strobes enter an RD_LAT-deep shift register, which shifts every cycle. Its output is twid_valid; the tag carried with k=63 is twid_last.
- Latency: address issued at cycle t -> twid_valid at t+RD_LAT.
- After issuing k=63 -> DRAIN.

DRAIN:
- Wait RD_LAT cycles until the valid pipe is empty, then go to IDLE.
- stage_start is accepted only in IDLE; anywhere else it produces a cmd_err pulse.

Other rules:
- busy = (state != IDLE).
- wEn=0 outside LOAD.
- Exactly 64 twid_valid pulses per stage; twid_last occurs exactly once per stage.

Optional Feature:
Macro: PIPE_FFT_TWID_LOAD_CKSUM_EN.

When the macro is defined:
- Added input ld_cksum[15:0], sampled together with the 64th word.
- Added output cksum_err, one-cycle pulse.
- During LOAD the controller accumulates a 16-bit modular sum of the four 16-bit slices of every written word.
- On the 64th word, a mismatch against ld_cksum -> cksum_err pulses together with load_done, and table_ok stays 0.

When the macro is undefined: no extra ports; table_ok is set unconditionally after 64 words.

Decomposition:
- Package pipe_fft_twid_pkg:
  - state enum (IDLE/LOAD/RUN/DRAIN);
  - TWID_DEPTH=64, TWID_ADDR_W=6, TWID_DATA_W=64;
  - CKSUM_W=16.
- Sub-module pipe_fft_twid_addr_gen (natural to split out):
  - inputs clk, nGrst, clr, adv, s;
  - outputs rAddr, k, last_issue.
- The controller instantiates it and owns the FSM, the load path and the valid pipe.

Test Plan:
- Load with ld_valid=1 continuously, data=i*0x0101: wEn high for 64 cycles, wAddr 0..63; load_done 1 cycle after the last write; table_ok=1.
- Load with ld_valid toggling every other cycle: exactly 64 writes, no address skips; load_done after the 64th accepted word.
- stage_idx=0, run_en=1: rAddr 0,1,...,63; twid_valid high for 64 consecutive cycles starting 2 cycles after the first issue; twid_last on the 64th; busy drops 2 cycles after the last issue.
- stage_idx=2: rAddr sequence 0,4,8,...,60,0,4,... (wraps, 64 issues); stage_idx=6: all 64 addresses are 0.
- run_en deasserted for 5 cycles mid-RUN at k=10: rAddr holds 40 (s=2); twid_valid gap of exactly 5 cycles; still 64 valids in total.
- Error and reset cases:
  - stage_start before any load -> cmd_err, busy stays 0.
  - nGrst pulsed at load word 30 -> all outputs 0, table_ok=0.
  - With PIPE_FFT_TWID_LOAD_CKSUM_EN and a wrong ld_cksum -> cksum_err pulses and table_ok stays 0.
